// File: rtl/flash_pkg.sv
// flash_pkg -- shared definitions for the flash prefetch buffer slice.
//
// Contents:
//   FLASH_WADDR_W   : width of a flash word address (15 bits)
//   FLASH_LAST_WORD : highest valid flash word address (304 rows x 64 cols - 1)
//   state_t         : controller state encoding
//
// Optional feature macro: FLASH_PREFETCH_EN. When it is undefined the
// PREFETCH state does not exist.

package flash_pkg;

    localparam int FLASH_WADDR_W = 15;
    localparam logic [FLASH_WADDR_W-1:0] FLASH_LAST_WORD = 15'h4BFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEMAND   = 2'd1,
        ST_WRITE    = 2'd2
`ifdef FLASH_PREFETCH_EN
        ,
        ST_PREFETCH = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo -- stream buffer of consecutive flash words.
//
// Entry k holds the word at head+k for k < count. The storage is a ring
// indexed from rd_ptr, so a skip-pop only moves pointers, never data.
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   lookup_addr         : word address to look up (the CPU request)
//   hit, hit_data       : lookup_addr is buffered / its data
//   pop                 : drop every entry up to and including the hit entry
//   push, push_data     : append the word at next_addr
//   flush               : discard all entries, keep head
//   load, load_addr     : discard all entries and restart the stream at load_addr
//   full                : count == DEPTH
//   next_addr, next_ok  : address of the next word to fetch, and whether it
//                         lies inside the flash (no wrap past LAST_WORD)

module prefetch_fifo
    import flash_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [FLASH_WADDR_W-1:0] LAST_WORD = FLASH_LAST_WORD
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [FLASH_WADDR_W-1:0] lookup_addr,
    output logic                     hit,
    output logic [31:0]              hit_data,
    input  logic                     pop,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     flush,
    input  logic                     load,
    input  logic [FLASH_WADDR_W-1:0] load_addr,
    output logic                     full,
    output logic [FLASH_WADDR_W-1:0] next_addr,
    output logic                     next_ok
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = FLASH_WADDR_W;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [AW-1:0] head_reg;
    logic [CW-1:0] count_reg;

    logic [AW-1:0] offset;
    logic [AW:0]   next_sum;

    // Modular subtraction: addresses below head give a huge offset and
    // therefore miss, which is exactly what a backward jump should do.
    assign offset    = lookup_addr - head_reg;
    assign hit       = offset < AW'(count_reg);
    assign hit_data  = mem[rd_ptr_reg + offset[PW-1:0]];
    assign full      = (count_reg == CW'(DEPTH));

    // One extra bit so that head+count past 0x7FFF cannot alias to a low
    // address and sneak under LAST_WORD.
    assign next_sum  = {1'b0, head_reg} + (AW + 1)'(count_reg);
    assign next_addr = next_sum[AW-1:0];
    assign next_ok   = (next_sum <= {1'b0, LAST_WORD});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            head_reg   <= '0;
            count_reg  <= '0;
        end else if (load) begin
            head_reg  <= load_addr;
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else if (pop && hit) begin
            head_reg   <= lookup_addr + AW'(1);
            rd_ptr_reg <= rd_ptr_reg + offset[PW-1:0] + PW'(1);
            count_reg  <= count_reg - offset[CW-1:0] - CW'(1);
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full && !load && !flush && !pop) begin
            mem[rd_ptr_reg + count_reg[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/flash_prefetch_buf.sv
// flash_prefetch_buf -- sequential-read prefetch buffer between the picoRV
// native memory bus and the user-flash cache controller.
//
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   cpu_valid/addr/wstrb/wdata       : CPU request (byte address, wstrb 0 = read)
//   cpu_ready, cpu_rdata             : one-cycle completion pulse with read data
//   fl_select/addr/wstrb/wdata       : request to the flash controller
//   fl_ready, fl_rdata               : flash completion pulse with read data
//
// Optional feature macro: FLASH_PREFETCH_EN. When defined, sequential reads
// are served from a DEPTH-word stream buffer that is refilled speculatively
// while the CPU is busy elsewhere. When undefined the buffer is absent and
// every read goes to flash.
//
// All outputs are registered; nothing on cpu_* reaches fl_* combinationally.

module flash_prefetch_buf
    import flash_pkg::*;
`ifdef FLASH_PREFETCH_EN
#(
    parameter int DEPTH = 4,
    parameter logic [FLASH_WADDR_W-1:0] LAST_WORD = FLASH_LAST_WORD
)
`endif
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_valid,
    input  logic [16:0]              cpu_addr,
    input  logic [3:0]               cpu_wstrb,
    input  logic [31:0]              cpu_wdata,
    output logic                     cpu_ready,
    output logic [31:0]              cpu_rdata,
    output logic                     fl_select,
    output logic [FLASH_WADDR_W-1:0] fl_addr,
    output logic [3:0]               fl_wstrb,
    output logic [31:0]              fl_wdata,
    input  logic                     fl_ready,
    input  logic [31:0]              fl_rdata
);

    state_t                   state_reg, state_next;
    logic                     cpu_ready_reg, cpu_ready_next;
    logic [31:0]              cpu_rdata_reg, cpu_rdata_next;
    logic                     fl_select_reg, fl_select_next;
    logic [FLASH_WADDR_W-1:0] fl_addr_reg, fl_addr_next;
    logic [3:0]               fl_wstrb_reg, fl_wstrb_next;
    logic [31:0]              fl_wdata_reg, fl_wdata_next;

    logic [FLASH_WADDR_W-1:0] wa;
    logic                     req;
    logic                     is_write;
    logic                     unused_addr_lsb;

    assign wa       = cpu_addr[16:2];
    // The cycle cpu_ready is high the CPU is still dropping cpu_valid, so
    // that request has already been served.
    assign req      = cpu_valid && !cpu_ready_reg;
    assign is_write = |cpu_wstrb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

`ifdef FLASH_PREFETCH_EN
    logic                     pf_en_reg, pf_en_next;
    logic                     fifo_hit;
    logic [31:0]              fifo_hit_data;
    logic                     fifo_pop, fifo_push, fifo_flush, fifo_load;
    logic                     fifo_full;
    logic [FLASH_WADDR_W-1:0] fifo_next_addr;
    logic                     fifo_next_ok;

    prefetch_fifo #(
        .DEPTH     (DEPTH),
        .LAST_WORD (LAST_WORD)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .lookup_addr (wa),
        .hit         (fifo_hit),
        .hit_data    (fifo_hit_data),
        .pop         (fifo_pop),
        .push        (fifo_push),
        .push_data   (fl_rdata),
        .flush       (fifo_flush),
        .load        (fifo_load),
        .load_addr   (fl_addr_reg + FLASH_WADDR_W'(1)),
        .full        (fifo_full),
        .next_addr   (fifo_next_addr),
        .next_ok     (fifo_next_ok)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cpu_ready_reg <= 1'b0;
            cpu_rdata_reg <= '0;
            fl_select_reg <= 1'b0;
            fl_addr_reg   <= '0;
            fl_wstrb_reg  <= '0;
            fl_wdata_reg  <= '0;
`ifdef FLASH_PREFETCH_EN
            pf_en_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cpu_ready_reg <= cpu_ready_next;
            cpu_rdata_reg <= cpu_rdata_next;
            fl_select_reg <= fl_select_next;
            fl_addr_reg   <= fl_addr_next;
            fl_wstrb_reg  <= fl_wstrb_next;
            fl_wdata_reg  <= fl_wdata_next;
`ifdef FLASH_PREFETCH_EN
            pf_en_reg     <= pf_en_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cpu_ready_next = 1'b0;
        cpu_rdata_next = cpu_rdata_reg;
        fl_select_next = fl_select_reg;
        fl_addr_next   = fl_addr_reg;
        fl_wstrb_next  = fl_wstrb_reg;
        fl_wdata_next  = fl_wdata_reg;
`ifdef FLASH_PREFETCH_EN
        pf_en_next     = pf_en_reg;
        fifo_pop       = 1'b0;
        fifo_push      = 1'b0;
        fifo_flush     = 1'b0;
        fifo_load      = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (req && is_write) begin
                    // Buffered words may now be stale; stop streaming until
                    // the next demand read re-anchors the buffer.
`ifdef FLASH_PREFETCH_EN
                    fifo_flush = 1'b1;
                    pf_en_next = 1'b0;
`endif
                    fl_select_next = 1'b1;
                    fl_addr_next   = wa;
                    fl_wstrb_next  = cpu_wstrb;
                    fl_wdata_next  = cpu_wdata;
                    state_next     = ST_WRITE;
                end else if (req) begin
`ifdef FLASH_PREFETCH_EN
                    if (fifo_hit) begin
                        cpu_ready_next = 1'b1;
                        cpu_rdata_next = fifo_hit_data;
                        fifo_pop       = 1'b1;
                    end else
`endif
                    begin
`ifdef FLASH_PREFETCH_EN
                        fifo_flush = 1'b1;
`endif
                        fl_select_next = 1'b1;
                        fl_addr_next   = wa;
                        fl_wstrb_next  = 4'h0;
                        state_next     = ST_DEMAND;
                    end
                end
`ifdef FLASH_PREFETCH_EN
                else if (pf_en_reg && !fifo_full && fifo_next_ok) begin
                    fl_select_next = 1'b1;
                    fl_addr_next   = fifo_next_addr;
                    fl_wstrb_next  = 4'h0;
                    state_next     = ST_PREFETCH;
                end
`endif
            end

            ST_DEMAND: begin
                if (fl_ready) begin
                    fl_select_next = 1'b0;
                    cpu_ready_next = 1'b1;
                    cpu_rdata_next = fl_rdata;
`ifdef FLASH_PREFETCH_EN
                    // Restart the stream just after the demanded word. At or
                    // beyond the last word there is nothing to stream, and
                    // head+1 could otherwise wrap to word 0.
                    fifo_load  = 1'b1;
                    pf_en_next = (fl_addr_reg < LAST_WORD);
`endif
                    state_next = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (fl_ready) begin
                    fl_select_next = 1'b0;
                    fl_wstrb_next  = 4'h0;
                    cpu_ready_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end

`ifdef FLASH_PREFETCH_EN
            ST_PREFETCH: begin
                if (fl_ready) begin
                    fl_select_next = 1'b0;
                    fifo_push      = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
`endif

            default: begin
                state_next     = ST_IDLE;
                fl_select_next = 1'b0;
            end
        endcase
    end

    assign cpu_ready = cpu_ready_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign fl_select = fl_select_reg;
    assign fl_addr   = fl_addr_reg;
    assign fl_wstrb  = fl_wstrb_reg;
    assign fl_wdata  = fl_wdata_reg;

endmodule

// File: tb/tb_flash_prefetch_buf.sv
// tb_flash_prefetch_buf -- directed self-checking bench for flash_prefetch_buf.
// A small flash-controller model answers every select after FL_WAIT edges
// and logs each read address and the last write. Expectations cover both
// builds (FLASH_PREFETCH_EN defined or not).

module tb_flash_prefetch_buf;
    import flash_pkg::*;

    localparam int FL_WAIT  = 2;
    // request sampled, FL_WAIT flash edges, one edge to register cpu_ready
    localparam int MISS_LAT = FL_WAIT + 2;
`ifdef FLASH_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif
    localparam int HIT_LAT = PF_EN ? 1 : MISS_LAT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        fl_select;
    logic [14:0] fl_addr;
    logic [3:0]  fl_wstrb;
    logic [31:0] fl_wdata;
    logic        fl_ready;
    logic [31:0] fl_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    flash_prefetch_buf dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wstrb (cpu_wstrb),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .fl_select (fl_select),
        .fl_addr   (fl_addr),
        .fl_wstrb  (fl_wstrb),
        .fl_wdata  (fl_wdata),
        .fl_ready  (fl_ready),
        .fl_rdata  (fl_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_data(input logic [14:0] a);
        return {a, 2'b10, a};
    endfunction

    // ---------------- flash controller model ----------------
    logic [14:0] rd_log[$];
    int          wait_cnt;
    int          wr_cnt = 0;
    logic [14:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fl_ready <= 1'b0;
            fl_rdata <= '0;
            wait_cnt <= 0;
        end else begin
            fl_ready <= 1'b0;
            if (fl_select && !fl_ready) begin
                if (wait_cnt == FL_WAIT - 1) begin
                    fl_ready <= 1'b1;
                    wait_cnt <= 0;
                    if (fl_wstrb == 4'h0) begin
                        fl_rdata <= word_data(fl_addr);
                        rd_log.push_back(fl_addr);
                    end else begin
                        fl_rdata <= '0;
                        wr_cnt   <= wr_cnt + 1;
                        wr_addr  <= fl_addr;
                        wr_data  <= fl_wdata;
                        wr_strb  <= fl_wstrb;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // lat = cycles from the sampling edge to cpu_ready (1 = next cycle);
    // 0 means the bound expired.
    task automatic cpu_xfer(input logic [16:0] addr, input logic [3:0] strb,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output int lat);
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = addr;
        cpu_wstrb = strb;
        cpu_wdata = wd;
        lat = 0;
        rd  = 'x;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) begin
                lat = i;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
    endtask

    function automatic logic [14:0] log_at(input int idx);
        if (idx < rd_log.size()) return rd_log[idx];
        return 15'h7FFF;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int sel_seen;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (cpu_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready);
        end
        n_cmp++;
        if (fl_select !== 1'b0) begin
            n_bad++; $display("FAIL reset_fl_select: got %b want 0", fl_select);
        end
        n_cmp++;
        if ({fl_addr, fl_wstrb, fl_wdata, cpu_rdata} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h/%h/%h/%h want all 0",
                              fl_addr, fl_wstrb, fl_wdata, cpu_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        sel_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (fl_select) sel_seen++;
        end
        n_cmp++;
        if (sel_seen !== 0 || rd_log.size() !== 0) begin
            n_bad++; $display("FAIL reset_no_prefetch: got %0d select cycles %0d reads want 0 0",
                              sel_seen, rd_log.size());
        end
    endtask

    task automatic test_sequential();
        logic [31:0] rd;
        int lat, s;
        s = rd_log.size();
        cpu_xfer(17'h00000, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== MISS_LAT) begin
            n_bad++; $display("FAIL seq_first_lat: got %0d want %0d", lat, MISS_LAT);
        end
        n_cmp++;
        if (rd !== word_data(15'h0)) begin
            n_bad++; $display("FAIL seq_first_data: got %h want %h", rd, word_data(15'h0));
        end
        n_cmp++;
        if (rd_log.size() !== s + 1 || log_at(s) !== 15'h0) begin
            n_bad++; $display("FAIL seq_first_flash: got %0d reads addr %h want 1 read addr 0000",
                              rd_log.size() - s, log_at(s));
        end
        idle(30);
        for (int w = 1; w <= 3; w++) begin
            s = rd_log.size();
            cpu_xfer(17'(w * 4), 4'h0, 32'h0, rd, lat);
            n_cmp++;
            if (lat !== HIT_LAT) begin
                n_bad++; $display("FAIL seq_lat word %0d: got %0d want %0d", w, lat, HIT_LAT);
            end
            n_cmp++;
            if (rd !== word_data(15'(w))) begin
                n_bad++; $display("FAIL seq_data word %0d: got %h want %h", w, rd, word_data(15'(w)));
            end
`ifndef FLASH_PREFETCH_EN
            n_cmp++;
            if (rd_log.size() !== s + 1 || log_at(s) !== 15'(w)) begin
                n_bad++; $display("FAIL seq_flash word %0d: got %0d reads addr %h want 1 read",
                                  w, rd_log.size() - s, log_at(s));
            end
`endif
            idle(30);
        end
    endtask

    task automatic test_skip();
        logic [31:0] rd;
        int lat;
        // anchor the stream at word 0 so the buffer holds words 1..4
        cpu_xfer(17'h00000, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== MISS_LAT) begin
            n_bad++; $display("FAIL skip_anchor_lat: got %0d want %0d", lat, MISS_LAT);
        end
        idle(30);
        cpu_xfer(17'h0000C, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== HIT_LAT) begin
            n_bad++; $display("FAIL skip_lat: got %0d want %0d", lat, HIT_LAT);
        end
        n_cmp++;
        if (rd !== word_data(15'h3)) begin
            n_bad++; $display("FAIL skip_data: got %h want %h", rd, word_data(15'h3));
        end
`ifdef FLASH_PREFETCH_EN
        n_cmp++;
        if (dut.u_fifo.count_reg !== 1 || dut.u_fifo.head_reg !== 15'h4) begin
            n_bad++; $display("FAIL skip_state: got count %0d head %h want 1 0004",
                              dut.u_fifo.count_reg, dut.u_fifo.head_reg);
        end
`endif
        idle(30);
    endtask

    task automatic test_new_region();
        logic [31:0] rd;
        int lat, s;
        s = rd_log.size();
        cpu_xfer(17'h00400, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== MISS_LAT) begin
            n_bad++; $display("FAIL region_lat: got %0d want %0d", lat, MISS_LAT);
        end
        n_cmp++;
        if (rd !== word_data(15'h100)) begin
            n_bad++; $display("FAIL region_data: got %h want %h", rd, word_data(15'h100));
        end
        idle(30);
        n_cmp++;
        if (rd_log.size() !== s + (PF_EN ? 5 : 1)) begin
            n_bad++; $display("FAIL region_reads: got %0d want %0d", rd_log.size() - s, PF_EN ? 5 : 1);
        end
        for (int i = 0; i < (PF_EN ? 5 : 1); i++) begin
            n_cmp++;
            if (log_at(s + i) !== 15'(15'h100 + i)) begin
                n_bad++; $display("FAIL region_addr %0d: got %h want %h", i, log_at(s + i), 15'h100 + i);
            end
        end
`ifdef FLASH_PREFETCH_EN
        n_cmp++;
        if (dut.u_fifo.count_reg !== 4 || dut.u_fifo.head_reg !== 15'h101) begin
            n_bad++; $display("FAIL region_state: got count %0d head %h want 4 0101",
                              dut.u_fifo.count_reg, dut.u_fifo.head_reg);
        end
`endif
    endtask

    task automatic test_write();
        logic [31:0] rd;
        int lat, s, w0;
        s  = rd_log.size();
        w0 = wr_cnt;
        cpu_xfer(17'h00008, 4'hF, 32'hCAFEF00D, rd, lat);
        n_cmp++;
        if (lat !== MISS_LAT) begin
            n_bad++; $display("FAIL write_lat: got %0d want %0d", lat, MISS_LAT);
        end
        n_cmp++;
        if (wr_cnt !== w0 + 1 || wr_addr !== 15'h2 || wr_data !== 32'hCAFEF00D || wr_strb !== 4'hF) begin
            n_bad++; $display("FAIL write_fwd: got n=%0d addr %h data %h strb %h want 1 0002 cafef00d f",
                              wr_cnt - w0, wr_addr, wr_data, wr_strb);
        end
`ifdef FLASH_PREFETCH_EN
        n_cmp++;
        if (dut.u_fifo.count_reg !== 0) begin
            n_bad++; $display("FAIL write_flush: got count %0d want 0", dut.u_fifo.count_reg);
        end
`endif
        idle(30);
        n_cmp++;
        if (rd_log.size() !== s || fl_select !== 1'b0) begin
            n_bad++; $display("FAIL write_no_prefetch: got %0d reads select %b want 0 0",
                              rd_log.size() - s, fl_select);
        end
    endtask

    task automatic test_last_word();
        logic [31:0] rd;
        int lat, s;
        s = rd_log.size();
        cpu_xfer(17'h12FF8, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== MISS_LAT || rd !== word_data(15'h4BFE)) begin
            n_bad++; $display("FAIL last_demand: got lat %0d data %h want %0d %h",
                              lat, rd, MISS_LAT, word_data(15'h4BFE));
        end
        idle(30);
        n_cmp++;
        if (rd_log.size() !== s + (PF_EN ? 2 : 1) || log_at(s) !== 15'h4BFE) begin
            n_bad++; $display("FAIL last_reads: got %0d first %h want %0d 4bfe",
                              rd_log.size() - s, log_at(s), PF_EN ? 2 : 1);
        end
`ifdef FLASH_PREFETCH_EN
        n_cmp++;
        if (log_at(s + 1) !== 15'h4BFF || dut.u_fifo.count_reg !== 1) begin
            n_bad++; $display("FAIL last_prefetch: got addr %h count %0d want 4bff 1",
                              log_at(s + 1), dut.u_fifo.count_reg);
        end
`endif
        cpu_xfer(17'h12FFC, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== HIT_LAT || rd !== word_data(15'h4BFF)) begin
            n_bad++; $display("FAIL last_top: got lat %0d data %h want %0d %h",
                              lat, rd, HIT_LAT, word_data(15'h4BFF));
        end
        idle(30);
        // either one prefetch and a hit, or two demand reads; never a wrap
        n_cmp++;
        if (rd_log.size() !== s + 2) begin
            n_bad++; $display("FAIL last_no_wrap: got %0d reads want 2", rd_log.size() - s);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, seen;
`ifdef FLASH_PREFETCH_EN
        cpu_xfer(17'h00040, 4'h0, 32'h0, rd, lat);
`else
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 17'h00040;
        cpu_wstrb = 4'h0;
`endif
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (fl_select) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1) begin
            n_bad++; $display("FAIL midrst_select_seen: got %0d want 1", seen);
        end
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        cpu_valid = 1'b0;
        #1;
        n_cmp++;
        if (fl_select !== 1'b0 || cpu_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_outputs: got select %b ready %b want 0 0", fl_select, cpu_ready);
        end
`ifdef FLASH_PREFETCH_EN
        n_cmp++;
        if (dut.u_fifo.count_reg !== 0 || dut.u_fifo.head_reg !== 15'h0) begin
            n_bad++; $display("FAIL midrst_fifo: got count %0d head %h want 0 0000",
                              dut.u_fifo.count_reg, dut.u_fifo.head_reg);
        end
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        cpu_xfer(17'h00014, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (lat !== MISS_LAT) begin
            n_bad++; $display("FAIL midrst_post_lat: got %0d want %0d", lat, MISS_LAT);
        end
        n_cmp++;
        if (rd !== word_data(15'h5) || rd_log.size() == 0 || rd_log[rd_log.size() - 1] !== 15'h5) begin
            n_bad++; $display("FAIL midrst_post_read: got data %h want %h from flash word 0005",
                              rd, word_data(15'h5));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_skip();
        test_new_region();
        test_write();
        test_last_word();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flash_prefetch_buf.md
# flash_prefetch_buf

Sequential-read prefetch buffer between the picoRV native memory bus and the user-flash cache controller. Accepts CPU requests already decoded to the flash region, serves sequential instruction fetches from a small stream buffer, and keeps the controller busy with speculative next-word reads while the CPU is elsewhere. Writes are forwarded unchanged and flush the buffer.

## Interface
- DEPTH, 4: stream-buffer entries (power of 2, 2..16)
- LAST_WORD, 15'h4BFF: highest valid flash word address (304 rows × 64 cols − 1)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_valid  in  1  request pending; held until cpu_ready
- cpu_addr  in  17  byte address; word address = cpu_addr[16:2]
- cpu_wstrb  in  4  0 = read, nonzero = write
- cpu_wdata  in  32  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ready = 1
- fl_select  out  1  request to flash controller; held until fl_ready
- fl_addr  out  15  flash word address; stable while fl_select = 1
- fl_wstrb  out  4  forwarded strobe
- fl_wdata  out  32  forwarded write data
- fl_ready  in  1  flash controller one-cycle completion pulse
- fl_rdata  in  32  flash read data, valid with fl_ready

## Operation
- Buffer: DEPTH words, head_addr (15 b), count (0..DEPTH). Entry k holds word head_addr+k.
- States: IDLE, DEMAND, PREFETCH, WRITE.
- IDLE, cpu_valid=1, cpu_ready=0, read, offset k = wa − head_addr with k < count: hit. Return entry k; pop k+1 entries (head_addr += k+1, count −= k+1). Stay IDLE.
- IDLE, read miss: flush (count=0), fl_addr=wa, fl_select=1, → DEMAND.
- DEMAND, fl_ready: cpu_rdata=fl_rdata, cpu_ready=1, head_addr=wa+1, count=0, pf_en=1, → IDLE.
- IDLE, write: flush, pf_en=0, forward addr/wstrb/wdata, → WRITE; fl_ready → cpu_ready, → IDLE.
- IDLE, no acceptable request, pf_en=1, count<DEPTH, head_addr+count ≤ LAST_WORD: issue read at head_addr+count, → PREFETCH.
- PREFETCH, fl_ready: push word (count+1), → IDLE. CPU requests arriving meanwhile wait; evaluated in IDLE next cycle. Prefetch is never aborted.
- fl_select cleared on the edge where fl_ready=1 (controller sees select low when back in its idle state).
- Address arithmetic 15-bit; prefetch never crosses LAST_WORD, never wraps to 0.
- Reset (any state, incl. mid-transaction): all outputs 0, count=0, head_addr=0, pf_en=0, state IDLE. Flash controller shares reset_n.

## Timing
- Hit: cpu_valid sampled at edge N → cpu_ready high cycle N+1.
- Miss: cpu_ready one cycle after fl_ready.
- A request is never accepted in the cycle cpu_ready=1 (CPU drops cpu_valid on that edge).
- Request during outstanding prefetch: extra latency ≤ remaining prefetch time + 1.
- cpu_ready and fl_select are registered; no combinational path from cpu_* to fl_*.

## Configuration
- FLASH_PREFETCH_EN defined: behaviour as above.
- Undefined: no PREFETCH state, pf_en forced 0, buffer removed; every read is a demand read (cpu_ready one cycle after fl_ready), writes unchanged.

## Structure
- flash_pkg: state encoding, FLASH_WADDR_W=15, FLASH_LAST_WORD=15'h4BFF.
- Sub-module prefetch_fifo: storage, head/count, hit lookup, skip-pop, push, flush.

## Test plan
- Sequential reads 0x000,0x004,0x008,0x00C after idle gap: first miss (1 flash read at word 0), rest hit with cpu_ready exactly 1 cycle after cpu_valid.
- Forward skip: buffer holds words 1..4, read word 3 → hit, count=1, head_addr=4.
- Miss into new region word 0x100 with buffer full: flush, demand read 0x100, then prefetch 0x101..0x104.
- Write wstrb=4'hF to word 2: forwarded once, cpu_ready after fl_ready, count=0, no prefetch until next read.
- Read word 0x4BFE: prefetch issues only 0x4BFF, then stops; count=1.
- reset_n low mid-PREFETCH: fl_select, cpu_ready=0 immediately, count=0; post-reset read of word 5 is a miss.
